// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit (Moore FSM).
// Ports:
//   clk, reset_n               - clock, asynchronous active-low reset
//   Op, funct3, funct7b5       - instruction fields from the instruction register
//   Zero, MemReady             - ALU zero flag, memory completion handshake
//   PCWrite, AdrSrc, IRWrite,
//   MemWrite, RegWrite         - datapath write enables / address select
//   ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc            - datapath mux selects
//   ALUControl                 - ALU operation
//   Illegal                    - pulses in DECODE on an unsupported opcode
//   State                      - current state code (debug)
module mc_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] Op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      ALUWB    = 4'd7,
      EXECUTEI = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10
   } state_t;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t     state;
   logic       branch;
   logic       pcupdate;
   logic [1:0] aluop;

   // State register; only the FSM state is reset, everything else is decoded from it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:    state <= MemReady ? DECODE : FETCH;
            DECODE: begin
               case (Op)
                  OP_LW, OP_SW: state <= MEMADR;
                  OP_R:         state <= EXECUTER;
                  OP_I:         state <= EXECUTEI;
                  OP_JAL:       state <= JAL;
                  OP_BEQ:       state <= BEQ;
                  default:      state <= FETCH;
               endcase
            end
            MEMADR:   state <= Op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state <= MemReady ? MEMWB : MEMREAD;
            MEMWB:    state <= FETCH;
            MEMWRITE: state <= MemReady ? FETCH : MEMWRITE;
            EXECUTER: state <= ALUWB;
            EXECUTEI: state <= ALUWB;
            ALUWB:    state <= FETCH;
            JAL:      state <= ALUWB;
            BEQ:      state <= FETCH;
            default:  state <= FETCH;
         endcase
      end
   end

   // Per-state output decode; MemReady gates the fetch enables combinationally.
   always_comb begin
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      aluop     = ALUOP_ADD;
      branch    = 1'b0;
      pcupdate  = 1'b0;
      Illegal   = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            pcupdate  = MemReady;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (Op)
               OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: Illegal = 1'b0;
               default:                                  Illegal = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            aluop   = ALUOP_FUNC;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            aluop   = ALUOP_FUNC;
         end
         ALUWB: RegWrite = 1'b1;
         JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite = (branch & Zero) | pcupdate;

   always_comb begin
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Subtract only for R-type with funct7b5 set; I-type addi ignores bit 30.
   always_comb begin
      case (aluop)
         ALUOP_ADD: ALUControl = 3'b000;
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNC: begin
            case (funct3)
               3'b000:  ALUControl = (Op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default:   ALUControl = 3'b000;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed, self-checking bench for mc_controller.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_mc_controller;

   logic       clk;
   logic       reset_n;
   logic [6:0] Op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;

   mc_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Op         (Op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal),
      .State      (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; leaves time just after the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset_n = 1'b0; Op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
      Zero = 1'b0; MemReady = 1'b1;
      step(); step(); settle();
      // Reset state
      check("rst_state", State, 4'd0);
      check("rst_regwrite", RegWrite, 1'b0);
      check("rst_memwrite", MemWrite, 1'b0);
      check("rst_illegal", Illegal, 1'b0);
      check("rst_irwrite_rdy", IRWrite, 1'b1);
      check("rst_pcwrite_rdy", PCWrite, 1'b1);
      MemReady = 1'b0; settle();
      check("rst_irwrite_nrdy", IRWrite, 1'b0);
      check("rst_pcwrite_nrdy", PCWrite, 1'b0);

      // Release reset with MemReady low: FETCH must hold
      step(); reset_n = 1'b1; settle();
      step(); settle();
      check("fetch_hold", State, 4'd0);
      check("fetch_srcb", ALUSrcB, 2'b10);
      check("fetch_ressrc", ResultSrc, 2'b10);

      // lw: 0,1,2,3,4,0
      MemReady = 1'b1; Op = 7'b0000011; settle();
      check("lw_immsrc", ImmSrc, 2'b00);
      step(); settle();
      check("lw_s1", State, 4'd1);
      check("lw_dec_srca", ALUSrcA, 2'b01);
      check("lw_dec_srcb", ALUSrcB, 2'b01);
      step(); settle();
      check("lw_s2", State, 4'd2);
      check("lw_adr_srca", ALUSrcA, 2'b10);
      step(); settle();
      check("lw_s3", State, 4'd3);
      check("lw_rd_adrsrc", AdrSrc, 1'b1);
      check("lw_rd_regwrite", RegWrite, 1'b0);
      step(); settle();
      check("lw_s4", State, 4'd4);
      check("lw_wb_regwrite", RegWrite, 1'b1);
      check("lw_wb_ressrc", ResultSrc, 2'b01);
      step(); settle();
      check("lw_s0", State, 4'd0);
      check("lw_end_regwrite", RegWrite, 1'b0);

      // sw with MemReady low for two cycles in MEMWRITE
      Op = 7'b0100011; settle();
      check("sw_immsrc", ImmSrc, 2'b01);
      step(); step(); step();
      MemReady = 1'b0; settle();
      check("sw_s5a", State, 4'd5);
      check("sw_mw1", MemWrite, 1'b1);
      check("sw_adrsrc", AdrSrc, 1'b1);
      step(); settle();
      check("sw_s5b", State, 4'd5);
      check("sw_mw2", MemWrite, 1'b1);
      step(); MemReady = 1'b1; settle();
      check("sw_s5c", State, 4'd5);
      check("sw_mw3", MemWrite, 1'b1);
      step(); settle();
      check("sw_s0", State, 4'd0);
      check("sw_mw_end", MemWrite, 1'b0);

      // beq, 3 cycles
      Op = 7'b1100011; Zero = 1'b1; settle();
      check("beq_immsrc", ImmSrc, 2'b10);
      step(); settle();
      check("beq_dec_pcwrite", PCWrite, 1'b0);
      step(); settle();
      check("beq_s10", State, 4'd10);
      check("beq_aluctl", ALUControl, 3'b001);
      check("beq_taken", PCWrite, 1'b1);
      Zero = 1'b0; settle();
      check("beq_nottaken", PCWrite, 1'b0);
      step(); settle();
      check("beq_s0", State, 4'd0);

      // R-type sub / add / slt
      Op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      step(); step(); settle();
      check("r_s6", State, 4'd6);
      check("r_sub", ALUControl, 3'b001);
      check("r_srcb", ALUSrcB, 2'b00);
      funct7b5 = 1'b0; settle();
      check("r_add", ALUControl, 3'b000);
      funct3 = 3'b010; settle();
      check("r_slt", ALUControl, 3'b101);
      step(); settle();
      check("r_s7", State, 4'd7);
      check("r_wb_regwrite", RegWrite, 1'b1);
      check("r_wb_ressrc", ResultSrc, 2'b00);
      step(); settle();
      check("r_s0", State, 4'd0);

      // I-type addi with bit 30 set must still add
      Op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      step(); step(); settle();
      check("i_s8", State, 4'd8);
      check("i_addi", ALUControl, 3'b000);
      check("i_srcb", ALUSrcB, 2'b01);
      funct3 = 3'b110; settle();
      check("i_or", ALUControl, 3'b011);
      funct3 = 3'b111; settle();
      check("i_and", ALUControl, 3'b010);
      step(); step(); settle();
      check("i_s0", State, 4'd0);

      // jal, 4 cycles
      Op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; settle();
      check("jal_immsrc", ImmSrc, 2'b11);
      step(); step(); settle();
      check("jal_s9", State, 4'd9);
      check("jal_pcwrite", PCWrite, 1'b1);
      check("jal_srca", ALUSrcA, 2'b01);
      check("jal_srcb", ALUSrcB, 2'b10);
      step(); settle();
      check("jal_s7", State, 4'd7);
      step(); settle();
      check("jal_s0", State, 4'd0);

      // Illegal opcode
      Op = 7'b1111111; settle();
      check("ill_immsrc", ImmSrc, 2'b00);
      step(); settle();
      check("ill_s1", State, 4'd1);
      check("ill_pulse", Illegal, 1'b1);
      check("ill_regwrite", RegWrite, 1'b0);
      step(); settle();
      check("ill_s0", State, 4'd0);
      check("ill_clear", Illegal, 1'b0);
      check("ill_memwrite", MemWrite, 1'b0);

      // Reset during MEMWB aborts the write at once
      Op = 7'b0000011;
      step(); step(); step(); step(); settle();
      check("arst_pre_s4", State, 4'd4);
      check("arst_pre_rw", RegWrite, 1'b1);
      reset_n = 1'b0; settle();
      check("arst_state", State, 4'd0);
      check("arst_regwrite", RegWrite, 1'b0);
      step(); reset_n = 1'b1; settle();
      step(); settle();
      check("arst_restart", State, 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
